mul_pipe: RTL



---
 rtl/mul_pkg.sv | 59 +++++
 rtl/mul_pipe_stage.sv | 60 ++++++
 rtl/mul_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier.
// Holds the result-mode encodings and the product formatting function that
// turns a full-precision product into {overflow, result}.
package mul_pkg;

    localparam int unsigned MUL_TRUNC  = 0;
    localparam int unsigned MUL_HIGH   = 1;
    localparam int unsigned MUL_SAT    = 2;

    localparam int unsigned MUL_MAX_W  = 32;
    localparam int unsigned MUL_PROD_W = 2 * MUL_MAX_W;

    // prod must already be sign- or zero-extended to MUL_PROD_W bits.
    // Returns {overflow, result}; only the low `width` bits of result matter.
    function automatic logic [MUL_MAX_W:0] mul_format(
        input logic [MUL_PROD_W-1:0] prod,
        input int unsigned           width,
        input logic                  is_signed,
        input int unsigned           mode
    );
        logic [MUL_PROD_W-1:0] mask;
        logic [MUL_PROD_W-1:0] smax;
        logic [MUL_PROD_W-1:0] smin;
        logic [MUL_PROD_W-1:0] res;
        logic                  ovf;

        mask = (MUL_PROD_W'(1) << width) - MUL_PROD_W'(1);
        smax = (MUL_PROD_W'(1) << (width - 1)) - MUL_PROD_W'(1);
        smin = ~smax;

        if (is_signed) begin
            ovf = ($signed(prod) > $signed(smax)) || ($signed(prod) < $signed(smin));
        end else begin
            ovf = (prod > mask);
        end

        res = prod & mask;
        case (mode)
            MUL_HIGH: begin
                res = (prod >> width) & mask;
                ovf = 1'b0;
            end
            MUL_SAT: begin
                if (ovf) begin
                    if (is_signed) begin
                        // Sign of the true product picks the rail.
                        res = prod[MUL_PROD_W-1] ? (smin & mask) : (smax & mask);
                    end else begin
                        res = mask;
                    end
                end
            end
            default: ;
        endcase

        return {ovf, MUL_MAX_W'(res)};
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One pipeline slot: a valid bit plus result/overflow payload.
// Ports: valid_i/res_i/ovf_i from the stage in front, ds_accept_i from the
// stage behind (or the consumer), accept_c_o back to the stage in front,
// valid_o/res_o/ovf_o registered contents.
module mul_pipe_stage
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic             ovf_i,
    input  logic             ds_accept_i,
    output logic             accept_c_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic             ovf_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    // An empty slot always accepts, so bubbles collapse under backpressure.
    assign accept_c_o = !valid_q || ds_accept_i;

    // Next-state: load on accept; payload only changes when a real item arrives.
    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        if (accept_c_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                res_d = res_i;
                ovf_d = ovf_i;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o = valid_q;
    assign res_o   = res_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready on both sides.
// Ports: I0/I1 operands, in_valid/in_ready input handshake, O/overflow
// result, out_valid/out_ready output handshake. in_ready is combinational
// from out_ready through the stage accept chain.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LATENCY  = 3,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned OUT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] O,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned PW = 2 * WIDTH;

    if (LATENCY < 1 || OUT_MODE > 2 || WIDTH < 2 || WIDTH > MUL_MAX_W) begin : g_bad_param
        $error("mul_pipe: illegal parameters WIDTH=%0d LATENCY=%0d OUT_MODE=%0d",
               WIDTH, LATENCY, OUT_MODE);
    end

    logic [PW-1:0]         a_ext, b_ext, prod;
    logic [MUL_PROD_W-1:0] prod_ext;
    logic [MUL_MAX_W:0]    fmt;
    logic                  unused_fmt;

    // Full-precision product, then formatted before entering stage 0.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext    = PW'($signed(I0));
            b_ext    = PW'($signed(I1));
        end else begin
            a_ext    = PW'(I0);
            b_ext    = PW'(I1);
        end
        prod = a_ext * b_ext;
        if (SIGNED != 0) begin
            prod_ext = MUL_PROD_W'($signed(prod));
        end else begin
            prod_ext = MUL_PROD_W'(prod);
        end
        fmt = mul_format(prod_ext, WIDTH, SIGNED != 0, OUT_MODE);
    end

    // Result bits above WIDTH are don't-care.
    assign unused_fmt = ^fmt;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic             acc;
        logic             vld;
        logic [WIDTH-1:0] res;
        logic             ovf;
        logic             up_vld;
        logic [WIDTH-1:0] up_res;
        logic             up_ovf;
        logic             ds_acc;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_res = fmt[WIDTH-1:0];
            assign up_ovf = fmt[MUL_MAX_W];
        end else begin : g_body
            assign up_vld = g_stage[k-1].vld;
            assign up_res = g_stage[k-1].res;
            assign up_ovf = g_stage[k-1].ovf;
        end

        if (k == LATENCY - 1) begin : g_tail
            assign ds_acc = out_ready;
        end else begin : g_mid
            assign ds_acc = g_stage[k+1].acc;
        end

        mul_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid_i    (up_vld),
            .res_i      (up_res),
            .ovf_i      (up_ovf),
            .ds_accept_i(ds_acc),
            .accept_c_o (acc),
            .valid_o    (vld),
            .res_o      (res),
            .ovf_o      (ovf)
        );
    end

    assign in_ready  = g_stage[0].acc;
    assign out_valid = g_stage[LATENCY-1].vld;
    assign O         = g_stage[LATENCY-1].res;
    assign overflow  = g_stage[LATENCY-1].ovf;

endmodule
